// File: rtl/lecture.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and key-code reporting.
// Define LECTURE_SYNC_EN to pass cols_in through a 2-flop synchronizer (adds 2 cycles).
module lecture #(
    parameter int unsigned SCAN_CYCLES     = 2700,
    parameter int unsigned DEBOUNCE_CYCLES = 2700
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols_in,
    output logic [3:0] rows_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int unsigned MaxCnt = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                      : DEBOUNCE_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(MaxCnt);

    typedef enum logic [1:0] {StScan, StDebPress, StPressed, StDebRelease} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              pulse_q, pulse_d;
    logic [3:0]        cols;
    logic [1:0]        first_col;

`ifdef LECTURE_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= cols_in;
            sync2_q <= sync1_q;
        end
    end

    assign cols = sync2_q;
`else
    assign cols = cols_in;
`endif

    // Scan downwards so the lowest-index low column wins.
    always_comb begin
        first_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) begin
                first_col = 2'(i);
            end
        end
    end

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        code_d  = code_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StScan: begin
                if (cnt_q >= ScanLast) begin
                    cnt_d = '0;
                    if (cols == 4'hF) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d   = first_col;
                        state_d = StDebPress;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDebPress: begin
                if (cols[col_q]) begin
                    state_d = StScan;
                    cnt_d   = '0;
                    row_d   = row_q + 2'd1;
                end else if (cnt_q >= DebLast) begin
                    code_d  = {row_q, col_q};
                    valid_d = 1'b1;
                    pulse_d = 1'b1;
                    state_d = StPressed;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPressed: begin
                if (cols[col_q]) begin
                    state_d = StDebRelease;
                    cnt_d   = '0;
                end
            end
            StDebRelease: begin
                if (!cols[col_q]) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q >= DebLast) begin
                    valid_d = 1'b0;
                    row_d   = row_q + 2'd1;
                    state_d = StScan;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StScan;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StScan;
            cnt_q   <= '0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign rows_out  = ~(4'b0001 << row_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_pulse = pulse_q;

endmodule

// File: tb/tb_lecture.sv
// Self-checking bench for the lecture keypad scanner, run with shortened scan/debounce times.
module tb_lecture;

    localparam int unsigned S = 40;
    localparam int unsigned D = 30;
`ifdef LECTURE_SYNC_EN
    localparam int unsigned Sync = 2;
`else
    localparam int unsigned Sync = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cols_in = 4'hF;
    logic [3:0] rows_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pulse;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_code = 4'd0;

    typedef struct {
        int         row;
        logic [3:0] cols;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    lecture #(
        .SCAN_CYCLES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cols_in  (cols_in),
        .rows_out (rows_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_pulse(key_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rowpat(input int r);
        case (r % 4)
            0:       rowpat = 4'b1110;
            1:       rowpat = 4'b1101;
            2:       rowpat = 4'b1011;
            default: rowpat = 4'b0111;
        endcase
    endfunction

    // Scoreboard: every pulse must match the oldest outstanding expected code.
    always @(negedge clk) begin
        if (!rst && key_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: actual code %0h required no pulse", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("pulse_code", key_code, e);
                check("pulse_valid", key_valid, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until the scanner starts a fresh dwell on row r.
    task automatic wait_row(input int r);
        int         n;
        logic [3:0] prev;
        logic       hit;
        n   = 0;
        hit = 1'b0;
        do begin
            prev = rows_out;
            tick();
            n++;
            hit = (rows_out == rowpat(r)) && (prev != rowpat(r));
        end while (!hit && n < int'(6 * S + 2 * D));
        check("row_reached", hit, 1);
    endtask

    task automatic press(input int r, input logic [3:0] c, input logic [3:0] code);
        int n;
        wait_row(r);
        cols_in = c;
        exp_q.push_back(code);
        n = 0;
        do begin
            tick();
            n++;
        end while (key_pulse !== 1'b1 && n < int'(S + D + 20));
        check("press_latency", n, S + D);
        tick();
        check("pulse_one_cycle", key_pulse, 0);
        check("valid_held", key_valid, 1);
        last_code = code;
    endtask

    task automatic release_key(input int r);
        int n;
        cols_in = 4'hF;
        n = 0;
        do begin
            tick();
            n++;
        end while (key_valid !== 1'b0 && n < int'(2 * D + 20));
        check("release_latency", n, D + 1 + Sync);
        check("code_kept", key_code, last_code);
        check("resume_next_row", rows_out, rowpat(r + 1));
    endtask

    initial begin
        vecs[0] = '{row: 1, cols: 4'b1101, code: 4'd5};
        vecs[1] = '{row: 0, cols: 4'b0111, code: 4'd3};
        vecs[2] = '{row: 2, cols: 4'b1110, code: 4'd8};
        vecs[3] = '{row: 3, cols: 4'b1011, code: 4'd14};
        vecs[4] = '{row: 2, cols: 4'b1001, code: 4'd9};

        // Reset values
        repeat (10) tick();
        check("rst_rows", rows_out, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_pulse", key_pulse, 0);
        check("rst_code", key_code, 0);

        // Idle scanning: each row dwells S cycles, wraps after row 3
        @(negedge clk);
        rst = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            int         n;
            logic [3:0] prev;
            n    = 0;
            prev = rows_out;
            do begin
                tick();
                n++;
            end while (rows_out == prev && n < int'(2 * S));
            check("scan_dwell", n, S);
            check("scan_row", rows_out, rowpat(r));
            check("scan_no_valid", key_valid, 0);
        end

        // Table-driven presses and releases
        foreach (vecs[i]) begin
            press(vecs[i].row, vecs[i].cols, vecs[i].code);
            if (i == 0) begin
                // Extra columns while held must be ignored.
                cols_in = 4'b1100;
                repeat (D + 5) tick();
                cols_in = 4'b0101;
                repeat (D + 5) tick();
                check("other_cols_code", key_code, 5);
                check("other_cols_valid", key_valid, 1);
                cols_in = vecs[i].cols;
                repeat (3) tick();
            end
            release_key(vecs[i].row);
        end

        // Release bounce shorter than debounce keeps the key held
        press(3, 4'b1110, 4'd12);
        cols_in = 4'hF;
        repeat (D / 2) tick();
        cols_in = 4'b1110;
        repeat (D + 10) tick();
        check("bounce_valid", key_valid, 1);
        check("bounce_code", key_code, 12);
        release_key(3);

        // Glitch: low at sample point but shorter than debounce
        wait_row(1);
        cols_in = 4'b1101;
        repeat (S + D / 2) tick();
        check("glitch_row_held", rows_out, 4'b1101);
        cols_in = 4'hF;
        repeat (Sync + 1) tick();
        check("glitch_abort_row", rows_out, 4'b1011);
        repeat (2 * S) tick();
        check("glitch_valid", key_valid, 0);
        check("glitch_code", key_code, last_code);

        // Asynchronous reset while a key is held
        press(0, 4'b0111, 4'd3);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rows", rows_out, 4'b1110);
        check("midrst_valid", key_valid, 0);
        check("midrst_pulse", key_pulse, 0);
        check("midrst_code", key_code, 0);
        cols_in = 4'hF;
        repeat (4) tick();
        @(negedge clk);
        rst = 1'b0;
        repeat (S + 2) tick();
        check("post_rst_rows", rows_out, 4'b1101);
        check("post_rst_valid", key_valid, 0);

        check("pending_pulses", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
